// File: rtl/rst_sequencer.sv
// Staged reset release: peripherals first, core second,
// gated by a synchronised PLL lock and a software core reset.
module rst_sequencer #(
  parameter int unsigned SYNC_STAGES           = 2,
  parameter int unsigned LOCK_STABLE_CYCLES    = 16,
  parameter int unsigned PERIPH_TO_CORE_CYCLES = 8,
  parameter int unsigned SW_RST_CYCLES         = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_locked,
  input  logic sw_rst_req,
  output logic periph_rst_o,
  output logic core_rst_o,
  output logic rst_done_o
);

  localparam int unsigned MAX_AB =
    (LOCK_STABLE_CYCLES > PERIPH_TO_CORE_CYCLES) ?
    LOCK_STABLE_CYCLES : PERIPH_TO_CORE_CYCLES;
  localparam int unsigned MAX_C =
    (MAX_AB > SW_RST_CYCLES) ? MAX_AB : SW_RST_CYCLES;
  localparam int unsigned CW = $clog2(MAX_C) + 1;

  localparam logic [CW-1:0] LOCK_LAST =
    CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] P2C_LAST =
    CW'(PERIPH_TO_CORE_CYCLES - 1);
  localparam logic [CW-1:0] SW_LAST =
    CW'(SW_RST_CYCLES - 1);

  typedef enum logic [2:0] {
    WAIT_LOCK,
    STABLE,
    PERIPH_WAIT,
    RUN,
    SW_RST
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;

  assign locked_s = sync_q[SYNC_STAGES-1];

  // Bring the asynchronous lock flag into the clk domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
    end
  end

  // Next state and shared counter; lock loss outranks all else
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    if (state_q != WAIT_LOCK && !locked_s) begin
      state_d = WAIT_LOCK;
    end else begin
      unique case (state_q)
        WAIT_LOCK: begin
          if (locked_s) state_d = STABLE;
        end
        STABLE: begin
          if (cnt_q == LOCK_LAST) state_d = PERIPH_WAIT;
          else cnt_d = cnt_q + 1'b1;
        end
        PERIPH_WAIT: begin
          if (cnt_q == P2C_LAST) state_d = RUN;
          else cnt_d = cnt_q + 1'b1;
        end
        RUN: begin
          if (sw_rst_req) state_d = SW_RST;
        end
        SW_RST: begin
          if (cnt_q == SW_LAST) state_d = RUN;
          else cnt_d = cnt_q + 1'b1;
        end
        default: state_d = WAIT_LOCK;
      endcase
    end
  end

  // State, counter and next-state-decoded output flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= WAIT_LOCK;
      cnt_q        <= '0;
      periph_rst_o <= 1'b1;
      core_rst_o   <= 1'b1;
      rst_done_o   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      periph_rst_o <= (state_d == WAIT_LOCK) ||
                      (state_d == STABLE);
      core_rst_o   <= (state_d != RUN);
      rst_done_o   <= (state_d == RUN);
    end
  end

endmodule
